dlfloat_div_seq: RTL

DLFLOAT_DIV_SEQ -- requirements
Module: dlfloat_div_seq

---
 rtl/dlfloat_div_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dlfloat_div_seq.sv
// Sequential DLFloat divider: restoring radix-2 mantissa division, one quotient bit
// per cycle, followed by a single round-to-nearest-even / special-case cycle.
module dlfloat_div_seq #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     q,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       exception_flags
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int QW   = MAN_W + 3;
    localparam int RW   = MAN_W + 2;
    localparam int XW   = EXP_W + 2;
    localparam int CW   = $clog2(QW);
    localparam logic [XW-1:0] EXP_MAX_C = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  NAN_C     = {1'b0, {(EXP_W + MAN_W){1'b1}}};

    typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

    state_t             state_r, state_s;
    logic [W-1:0]       a_r, b_r, q_r;
    logic [TAG_W-1:0]   tag_r, out_tag_r;
    logic [4:0]         flags_r;
    logic [RW-1:0]      rem_r, div_s, diff_s, rem_next_s;
    logic [QW-1:0]      quo_r;
    logic [CW-1:0]      cnt_r;
    logic               qbit_s;

    logic               sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [EXP_W-1:0]   ea_s, eb_s;
    logic [XW-1:0]      exp_raw_s, exp_norm_s, exp_fin_s;
    logic [MAN_W-1:0]   mant_pre_s, mant_fin_s;
    logic [MAN_W:0]     mant_sum_s;
    logic               guard_s, sticky_s, round_up_s, inexact_s, ovf_s, unf_s;
    logic [W-1:0]       res_q_s;
    logic [4:0]         res_flags_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = in_valid ? DIVIDE : IDLE;
            DIVIDE:  state_s = (cnt_r == CW'(QW - 1)) ? ROUND : DIVIDE;
            ROUND:   state_s = DONE;
            DONE:    state_s = out_ready ? IDLE : DONE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // One restoring-division step: subtract the divisor when it fits, then shift
    always_comb begin
        div_s      = {1'b0, 1'b1, b_r[MAN_W-1:0]};
        qbit_s     = (rem_r >= div_s);
        diff_s     = qbit_s ? (rem_r - div_s) : rem_r;
        rem_next_s = {diff_s[RW-2:0], 1'b0};
    end

    assign sign_s   = a_r[W-1] ^ b_r[W-1];
    assign ea_s     = a_r[W-2:MAN_W];
    assign eb_s     = b_r[W-2:MAN_W];
    assign a_zero_s = (ea_s == '0);
    assign b_zero_s = (eb_s == '0);
    assign a_inf_s  = (ea_s == {EXP_W{1'b1}}) && (a_r[MAN_W-1:0] == '0);
    assign b_inf_s  = (eb_s == {EXP_W{1'b1}}) && (b_r[MAN_W-1:0] == '0);
    assign a_nan_s  = (ea_s == {EXP_W{1'b1}}) && (a_r[MAN_W-1:0] != '0);
    assign b_nan_s  = (eb_s == {EXP_W{1'b1}}) && (b_r[MAN_W-1:0] != '0);

    // Normalise, round to nearest even, then resolve special operands and range limits
    always_comb begin
        exp_raw_s = {2'b00, ea_s} - {2'b00, eb_s} + XW'(BIAS);
        if (quo_r[QW-1]) begin
            mant_pre_s = quo_r[QW-2:2];
            guard_s    = quo_r[1];
            sticky_s   = quo_r[0] | (|rem_r);
            exp_norm_s = exp_raw_s;
        end else begin
            mant_pre_s = quo_r[QW-3:1];
            guard_s    = quo_r[0];
            sticky_s   = |rem_r;
            exp_norm_s = exp_raw_s - XW'(1);
        end
        round_up_s = guard_s & (sticky_s | mant_pre_s[0]);
        inexact_s  = guard_s | sticky_s;
        mant_sum_s = {1'b0, mant_pre_s} + {{MAN_W{1'b0}}, round_up_s};
        if (mant_sum_s[MAN_W]) begin
            mant_fin_s = '0;
            exp_fin_s  = exp_norm_s + XW'(1);
        end else begin
            mant_fin_s = mant_sum_s[MAN_W-1:0];
            exp_fin_s  = exp_norm_s;
        end
        ovf_s = !exp_fin_s[XW-1] && (exp_fin_s >= EXP_MAX_C);
        unf_s = exp_fin_s[XW-1] || (exp_fin_s == '0);

        if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            res_q_s = NAN_C;
            res_flags_s = 5'b10000;
        end else if (a_nan_s || b_nan_s) begin
            res_q_s = NAN_C;
            res_flags_s = 5'b00000;
        end else if (b_zero_s && !a_inf_s) begin
            res_q_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags_s = 5'b00001;
        end else if (a_inf_s) begin
            res_q_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags_s = 5'b00000;
        end else if (a_zero_s || b_inf_s) begin
            res_q_s = {sign_s, {(W - 1){1'b0}}};
            res_flags_s = 5'b00000;
        end else if (ovf_s) begin
            res_q_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_flags_s = 5'b01100;
        end else if (unf_s) begin
            res_q_s = {sign_s, {(W - 1){1'b0}}};
            res_flags_s = 5'b01010;
        end else begin
            res_q_s = {sign_s, exp_fin_s[EXP_W-1:0], mant_fin_s};
            res_flags_s = {1'b0, inexact_s, 3'b000};
        end
    end

    // Operand capture, division iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            tag_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            cnt_r     <= '0;
            q_r       <= '0;
            out_tag_r <= '0;
            flags_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        tag_r <= in_tag;
                        rem_r <= {1'b0, 1'b1, a[MAN_W-1:0]};
                        quo_r <= '0;
                        cnt_r <= '0;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[QW-2:0], qbit_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                ROUND: begin
                    q_r       <= res_q_s;
                    flags_r   <= res_flags_s;
                    out_tag_r <= tag_r;
                end
                default: begin
                    q_r <= q_r;
                end
            endcase
        end
    end

    assign q               = q_r;
    assign out_tag         = out_tag_r;
    assign exception_flags = flags_r;

endmodule
